// File: rtl/encoder_16x4_serial_pkg.sv
// Shared types and widths for the serial 16-to-4 encoder.
// Holds the vector/index widths, FSM state type and a one-hot helper.
package encoder_pkg;

    localparam int VEC_W = 16;
    localparam int IDX_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    function automatic logic single_bit(input logic [VEC_W-1:0] v);
        return (v != '0) && ((v & (v - VEC_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/encoder_16x4_serial_prio_enc16.sv
// Combinational 16-bit priority encoder with a rotating start point.
// Returns the first set bit at index >= start, wrapping 15 -> 0.
module prio_enc16
    import encoder_pkg::*;
(
    input  logic [VEC_W-1:0] vec,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [IDX_W-1:0] pos;

    // Scan from the far end back to start so the nearest hit wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = VEC_W - 1; k >= 0; k--) begin
            pos = start + IDX_W'(k);
            if (vec[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/encoder_16x4_serial.sv
// Serial encoder: captures a multi-hot vector, emits one index per transfer.
// ENC_ROUND_ROBIN_EN selects a persistent rotating start pointer.
module encoder_16x4_serial
    import encoder_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [VEC_W-1:0] I,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] Y,
    output logic             last,
    output logic             zero_err
);

    state_t           state_q;
    state_t           state_d;
    logic [VEC_W-1:0] pending_q;
    logic [VEC_W-1:0] pending_d;
    logic             zero_err_q;
    logic             zero_err_d;

    logic [IDX_W-1:0] start;
    logic [IDX_W-1:0] sel;
    logic             found;
    logic             accept;
    logic             xfer;
    logic             single;

    prio_enc16 u_prio (
        .vec   (pending_q),
        .start (start),
        .idx   (sel),
        .found (found)
    );

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == EMIT);
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;
    assign single    = single_bit(pending_q);
    assign zero_err  = zero_err_q;

    always_comb begin
        Y    = '0;
        last = 1'b0;
        if (out_valid && found) begin
            Y    = sel;
            last = single;
        end
    end

`ifdef ENC_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (xfer) begin
            ptr_q <= sel + IDX_W'(1);
        end
    end

    assign start = ptr_q;
`else
    assign start = '0;
`endif

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        zero_err_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (I == '0) begin
                        zero_err_d = 1'b1;
                    end else begin
                        pending_d = I;
                        state_d   = EMIT;
                    end
                end
            end
            EMIT: begin
                if (xfer) begin
                    pending_d = pending_q & ~(VEC_W'(1) << sel);
                    if (last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                pending_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            zero_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            zero_err_q <= zero_err_d;
        end
    end

endmodule

// File: tb/tb_encoder_16x4_serial.sv
// Directed bench for encoder_16x4_serial, fixed or round-robin build.
module tb_encoder_16x4_serial;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] I;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  Y;
    logic        last;
    logic        zero_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    encoder_16x4_serial dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .I         (I),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (Y),
        .last      (last),
        .zero_err  (zero_err)
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // out_valid, Y, last, in_ready packed for compact checks
    function automatic logic [15:0] pk();
        return {9'd0, out_valid, Y, last, in_ready};
    endfunction

    function automatic logic [15:0] ex(input logic v, input logic [3:0] y,
                                       input logic l, input logic r);
        return {9'd0, v, y, l, r};
    endfunction

`ifdef ENC_ROUND_ROBIN_EN
    localparam logic [3:0] FF_BASE = 4'd2;
    localparam logic [3:0] V30_A   = 4'd5;
    localparam logic [3:0] V30_B   = 4'd4;
`else
    localparam logic [3:0] FF_BASE = 4'd0;
    localparam logic [3:0] V30_A   = 4'd4;
    localparam logic [3:0] V30_B   = 4'd5;
`endif

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        I         = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        chk("reset_out", pk(), ex(1'b0, 4'd0, 1'b0, 1'b1));
        chk("reset_zerr", {15'd0, zero_err}, 16'd0);
        rst = 1'b0;

        // all-zero vector
        in_valid = 1'b1;
        I        = 16'h0000;
        @(negedge clk);
        in_valid = 1'b0;
        chk("zero_pulse", {15'd0, zero_err}, 16'd1);
        chk("zero_out", pk(), ex(1'b0, 4'd0, 1'b0, 1'b1));
        @(negedge clk);
        chk("zero_clr", {15'd0, zero_err}, 16'd0);
        chk("zero_idle", pk(), ex(1'b0, 4'd0, 1'b0, 1'b1));

        // 8421 streaming; new I during EMIT must be ignored
        out_ready = 1'b1;
        in_valid  = 1'b1;
        I         = 16'h8421;
        @(negedge clk);
        I = 16'h0F0F;
        chk("s8421_y0", pk(), ex(1'b1, 4'd0, 1'b0, 1'b0));
        @(negedge clk);
        chk("s8421_y5", pk(), ex(1'b1, 4'd5, 1'b0, 1'b0));
        @(negedge clk);
        chk("s8421_y10", pk(), ex(1'b1, 4'd10, 1'b0, 1'b0));
        @(negedge clk);
        in_valid = 1'b0;
        chk("s8421_y15", pk(), ex(1'b1, 4'd15, 1'b1, 1'b0));
        @(negedge clk);
        chk("s8421_done", pk(), ex(1'b0, 4'd0, 1'b0, 1'b1));
        chk("s8421_zerr", {15'd0, zero_err}, 16'd0);

        // 0003 with backpressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        I         = 16'h0003;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("hold_y0", pk(), ex(1'b1, 4'd0, 1'b0, 1'b0));
            if (c < 2) @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("hold_y1", pk(), ex(1'b1, 4'd1, 1'b1, 1'b0));
        @(negedge clk);
        chk("hold_done", pk(), ex(1'b0, 4'd0, 1'b0, 1'b1));

        // FFFF aborted by reset after four transfers
        in_valid = 1'b1;
        I        = 16'hFFFF;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("ffff_seq", pk(), ex(1'b1, FF_BASE + 4'(c), 1'b0, 1'b0));
            @(negedge clk);
        end
        chk("ffff_5th", pk(), ex(1'b1, FF_BASE + 4'd4, 1'b0, 1'b0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("ffff_rst", pk(), ex(1'b0, 4'd0, 1'b0, 1'b1));
        @(negedge clk);
        chk("ffff_quiet", pk(), ex(1'b0, 4'd0, 1'b0, 1'b1));

        // 0011 then 0030: pointer behaviour
        in_valid = 1'b1;
        I        = 16'h0011;
        @(negedge clk);
        in_valid = 1'b0;
        chk("v11_a", pk(), ex(1'b1, 4'd0, 1'b0, 1'b0));
        @(negedge clk);
        chk("v11_b", pk(), ex(1'b1, 4'd4, 1'b1, 1'b0));
        @(negedge clk);
        in_valid = 1'b1;
        I        = 16'h0030;
        @(negedge clk);
        in_valid = 1'b0;
        chk("v30_a", pk(), ex(1'b1, V30_A, 1'b0, 1'b0));
        @(negedge clk);
        chk("v30_b", pk(), ex(1'b1, V30_B, 1'b1, 1'b0));
        @(negedge clk);
        chk("v30_done", pk(), ex(1'b0, 4'd0, 1'b0, 1'b1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/encoder_16x4_serial.md
ENCODER_16X4_SERIAL -- requirements
Module: encoder_16x4_serial

Interface
REQ-001 Parameters: none; vector width fixed at 16, index width fixed at 4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  upstream presents request vector on I.
REQ-005 in_ready  output  1  block can accept a new vector.
REQ-006 I  input  16  multi-hot request vector; bit k set = event k pending.
REQ-007 out_valid  output  1  Y holds a valid encoded index.
REQ-008 out_ready  input  1  downstream accepts Y this cycle.
REQ-009 Y  output  4  binary index of the selected pending bit.
REQ-010 last  output  1  current Y is the final index of the captured vector.
REQ-011 zero_err  output  1  one-cycle pulse: accepted vector was all-zero.

Function
REQ-012 FSM states: IDLE, EMIT; the block SHALL encode, one index per transfer, every set bit of each accepted vector.
REQ-013 in_ready = 1 in IDLE only; out_valid = 1 in EMIT only.
REQ-014 Accept = in_valid && in_ready; on accept with I != 0: pending <= I, go to EMIT next cycle.
REQ-015 Accept with I == 0: stay IDLE, zero_err = 1 for exactly the following cycle, no output produced.
REQ-016 Latency: first out_valid asserted the cycle after accept.
REQ-017 In EMIT, Y = index of selected bit of pending (selection per REQ-024/025), decoded combinationally from registered pending.
REQ-018 Transfer = out_valid && out_ready; on transfer the selected bit of pending SHALL clear.
REQ-019 last = out_valid && (pending has exactly one bit set).
REQ-020 Transfer with last = 1: go to IDLE; in_ready high the next cycle (no same-cycle re-accept).
REQ-021 Y, last SHALL hold stable while out_valid && !out_ready (no change without transfer).
REQ-022 in_valid and I ignored outside IDLE; no input vector is lost or merged.
REQ-023 Y = 4'd0, last = 0 whenever out_valid = 0.

Configuration
REQ-024 Macro ENC_ROUND_ROBIN_EN undefined: fixed priority, lowest set index selected first.
REQ-025 ENC_ROUND_ROBIN_EN defined: rotating pointer ptr[3:0]; select first set bit at index >= ptr, wrapping 15 -> 0; on transfer ptr <= Y + 1 (mod 16); ptr persists across vectors, reset to 0.

Reset
REQ-026 rst SHALL, at the next clock edge, force state IDLE, pending 0, ptr 0 (if present), zero_err 0.
REQ-027 Reset values: in_ready 1, out_valid 0, Y 0, last 0, zero_err 0.
REQ-028 rst asserted mid-EMIT SHALL discard remaining pending bits with no further output.
REQ-029 rst has priority over any simultaneous accept or transfer.

Structure
REQ-030 Shared package encoder_pkg SHALL hold VEC_W = 16, IDX_W = 4 and the FSM state typedef.
REQ-031 One sub-module prio_enc16 (combinational: 16-bit vector + 4-bit start pointer -> 4-bit index + found flag); round-robin and fixed modes both use it (fixed mode ties pointer to 0).

Verification
REQ-032 I = 16'h0000 accepted -> no out_valid, zero_err = 1 for one cycle, in_ready stays 1.
REQ-033 I = 16'h8421, out_ready = 1 constant -> Y = 0, 5, 10, 15 on consecutive cycles; last only with 15; in_ready high cycle after.
REQ-034 I = 16'h0003, out_ready low 3 cycles -> Y = 0 held stable 3 cycles, then 0, 1 on transfers.
REQ-035 I = 16'hFFFF, rst pulsed after 4 transfers -> out_valid 0 next cycle, in_ready 1, no further indices.
REQ-036 ENC_ROUND_ROBIN_EN: I = 16'h0011 (emits 0, 4, ptr = 5), then I = 16'h0030 -> emits 5, 4; without macro -> 4, 5.
REQ-037 in_valid held high with new I during EMIT -> ignored; only the captured vector's indices appear.
